tone_phase_gen: RTL and testbench

//  Phase-accumulator NCO; drives the ADDR input of the downstream sine-table ROM (1-cycle registered lookup).

---
 rtl/mss_tone_pkg.sv | 23 ++
 rtl/tone_glide.sv | 33 +++
 rtl/tone_phase_gen.sv | 125 ++++++++++++
 tb/tb_tone_phase_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mss_tone_pkg.sv
// Shared types and helpers for the tone phase generator (TONE_GLIDE_EN selects glide retuning).
package mss_tone_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } tone_state_t;

  localparam int ACC_W_DEF = 24;

  // The sine table has no entry for the all-ones code, so it folds onto address 0.
  function automatic logic [31:0] addr_fold(input logic [31:0] code, input int width);
    logic [31:0] max_code;
    max_code = (32'd1 << width) - 32'd1;
    if (code == max_code) begin
      return 32'd0;
    end else begin
      return code;
    end
  endfunction

endpackage

// File: rtl/tone_glide.sv
// Portamento stepper: moves the active tuning word toward its target by GLIDE_STEP, clamping at the target.
module tone_glide
  import mss_tone_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int GLIDE_STEP = 256
) (
  input  logic [ACC_W-1:0] cur_word,
  input  logic [ACC_W-1:0] target_word,
  output logic [ACC_W-1:0] next_word
);

  localparam logic [ACC_W-1:0] STEP = ACC_W'(GLIDE_STEP);

  // One glide step, never overshooting the target.
  always_comb begin
    next_word = cur_word;
    if (cur_word > target_word) begin
      if ((cur_word - target_word) > STEP) begin
        next_word = cur_word - STEP;
      end else begin
        next_word = target_word;
      end
    end else begin
      if ((target_word - cur_word) > STEP) begin
        next_word = cur_word + STEP;
      end else begin
        next_word = target_word;
      end
    end
  end

endmodule

// File: rtl/tone_phase_gen.sv
// Phase-accumulator NCO addressing a sine ROM; tones end only at a phase wrap.
// Define TONE_GLIDE_EN to glide between tuning words instead of retuning instantly.
module tone_phase_gen
  import mss_tone_pkg::*;
#(
  parameter int COUNT_SIZE = 8,
  parameter int ACC_W      = ACC_W_DEF
`ifdef TONE_GLIDE_EN
  , parameter int GLIDE_STEP = 256
`endif
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  sample_tick,
  input  logic                  tone_on,
  input  logic                  tune_load,
  input  logic [ACC_W-1:0]      tune_word,
  output logic [COUNT_SIZE-1:0] ADDR,
  output logic                  busy,
  output logic                  wrap_pulse
);

  tone_state_t           state_r, state_next_s;
  logic [ACC_W-1:0]      acc_r, acc_next_s;
  logic [ACC_W-1:0]      pend_word_r, act_word_r, act_next_s, word_target_s;
  logic [ACC_W:0]        sum_s;
  logic                  wrap_next_s;
  logic [COUNT_SIZE-1:0] addr_top_s, addr_next_s;

  // A word loaded on a tick is forwarded so it takes effect from the very next tick.
  assign word_target_s = tune_load ? tune_word : pend_word_r;

`ifdef TONE_GLIDE_EN
  tone_glide #(
    .ACC_W      (ACC_W),
    .GLIDE_STEP (GLIDE_STEP)
  ) u_glide (
    .cur_word    (act_word_r),
    .target_word (word_target_s),
    .next_word   (act_next_s)
  );
`else
  assign act_next_s = word_target_s;
`endif

  assign sum_s       = {1'b0, acc_r} + {1'b0, act_word_r};
  assign addr_top_s  = acc_next_s[ACC_W-1 -: COUNT_SIZE];
  assign addr_next_s = COUNT_SIZE'(addr_fold(32'(addr_top_s), COUNT_SIZE));

  // Start/stop control and phase advance; FINISH only drops to IDLE on a wrap or a zero word.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    wrap_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        acc_next_s = {ACC_W{1'b0}};
        if (tone_on) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (sample_tick) begin
          acc_next_s  = sum_s[ACC_W-1:0];
          wrap_next_s = sum_s[ACC_W];
        end else begin
          acc_next_s  = acc_r;
        end
        if (!tone_on) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = RUN;
        end
      end
      FINISH: begin
        if (sample_tick) begin
          acc_next_s  = sum_s[ACC_W-1:0];
          wrap_next_s = sum_s[ACC_W];
        end else begin
          acc_next_s  = acc_r;
        end
        if (tone_on) begin
          state_next_s = RUN;
        end else if (sample_tick && (sum_s[ACC_W] || (act_word_r == {ACC_W{1'b0}}))) begin
          state_next_s = IDLE;
          acc_next_s   = {ACC_W{1'b0}};
        end else begin
          state_next_s = FINISH;
        end
      end
      default: begin
        state_next_s = IDLE;
        acc_next_s   = {ACC_W{1'b0}};
      end
    endcase
  end

  // State, phase, tuning words and registered outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      pend_word_r <= {ACC_W{1'b0}};
      act_word_r  <= {ACC_W{1'b0}};
      ADDR        <= {COUNT_SIZE{1'b0}};
      busy        <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      acc_r      <= acc_next_s;
      ADDR       <= addr_next_s;
      busy       <= (state_next_s != IDLE);
      wrap_pulse <= wrap_next_s;
      if (tune_load) begin
        pend_word_r <= tune_word;
      end
      if (sample_tick) begin
        act_word_r <= act_next_s;
      end
    end
  end

endmodule

// File: tb/tb_tone_phase_gen.sv
// Randomised and directed bench for tone_phase_gen against a behavioural NCO model.
module tb_tone_phase_gen;

  logic        CLK, RESETn, sample_tick, tone_on, tune_load;
  logic [23:0] tune_word;
  logic [7:0]  ADDR;
  logic        busy, wrap_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int wrap_seen = 0;

  tone_phase_gen dut (
    .CLK(CLK), .RESETn(RESETn), .sample_tick(sample_tick), .tone_on(tone_on),
    .tune_load(tune_load), .tune_word(tune_word), .ADDR(ADDR), .busy(busy),
    .wrap_pulse(wrap_pulse)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase as a plain integer modulo 2**24, tone as playing/stopping flags.
  localparam longint MODV = 64'd1 << 24;
  longint m_phase, m_word, m_pend, m_sum, m_target;
  bit     m_play, m_stop, was_play, was_stop, m_carry;
  logic [7:0] e_addr;
  bit     e_busy, e_wrap;
  longint top;

  initial begin
    m_phase = 0; m_word = 0; m_pend = 0; m_play = 0; m_stop = 0;
    e_addr = 8'd0; e_busy = 1'b0; e_wrap = 1'b0;
    forever begin
      @(posedge CLK);
      if (!RESETn) begin
        m_phase = 0; m_word = 0; m_pend = 0; m_play = 0; m_stop = 0;
        e_wrap = 1'b0;
      end else begin
        was_play = m_play;
        was_stop = m_stop;
        e_wrap = 1'b0;
        if (was_play && sample_tick) begin
          m_sum   = m_phase + m_word;
          m_carry = (m_sum >= MODV);
          m_phase = m_sum % MODV;
          e_wrap  = m_carry;
          if (was_stop && !tone_on && (m_carry || m_word == 0)) begin
            m_play = 0; m_stop = 0; m_phase = 0;
          end
        end
        if (!was_play) begin
          if (tone_on) m_play = 1;
        end else if (!was_stop) begin
          if (!tone_on) m_stop = 1;
        end else if (tone_on) begin
          m_stop = 0;
        end
        m_target = tune_load ? longint'(tune_word) : m_pend;
        if (sample_tick) begin
`ifdef TONE_GLIDE_EN
          if (m_target > m_word + 256) m_word = m_word + 256;
          else if (m_target + 256 < m_word) m_word = m_word - 256;
          else m_word = m_target;
`else
          m_word = m_target;
`endif
        end
        if (tune_load) m_pend = tune_word;
      end
      top = (m_phase >> 16) & 255;
      e_addr = (top == 255) ? 8'd0 : 8'(top);
      e_busy = m_play;
      #1;
      check("addr", 32'(ADDR), 32'(e_addr));
      check("busy", 32'(busy), 32'(e_busy));
      check("wrap", 32'(wrap_pulse), 32'(e_wrap));
      if (wrap_pulse === 1'b1) wrap_seen++;
    end
  end

  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic load_word(input logic [23:0] w);
    tune_load = 1'b1;
    tune_word = w;
    @(negedge CLK);
    tune_load = 1'b0;
  endtask

  task automatic stop_tone();
    tone_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      do_tick();
    end
    check("stop_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  int ticks;
  logic [23:0] rw;
  int r;

  initial begin
    RESETn = 1'b0; sample_tick = 1'b0; tone_on = 1'b0; tune_load = 1'b0; tune_word = 24'd0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    check("reset_addr", 32'(ADDR), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Idle ticks must not move the phase.
    repeat (20) do_tick();
    check("t1_addr", 32'(ADDR), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_nowrap", 32'(wrap_seen), 32'd0);

`ifndef TONE_GLIDE_EN
    // Unit step per tick, fold at 0xFF, wrap on tick 256.
    load_word(24'h010000);
    do_tick();
    tone_on = 1'b1;
    @(negedge CLK);
    do_tick();
    check("t2_tick1", 32'(ADDR), 32'h01);
    do_tick();
    check("t2_tick2", 32'(ADDR), 32'h02);
    do_tick();
    check("t2_tick3", 32'(ADDR), 32'h03);
    repeat (251) do_tick();
    check("t2_tick254", 32'(ADDR), 32'hFE);
    do_tick();
    check("t2_tick255_fold", 32'(ADDR), 32'h00);
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    check("t2_wrap_pulse", 32'(wrap_pulse), 32'd1);
    check("t2_wrap_addr", 32'(ADDR), 32'h00);
    repeat (3) @(negedge CLK);
    load_word(24'h000000);
    stop_tone();

    // Stop request completes only at the wrap.
    load_word(24'h100000);
    do_tick();
    tone_on = 1'b1;
    @(negedge CLK);
    repeat (5) do_tick();
    check("t3_addr50", 32'(ADDR), 32'h50);
    tone_on = 1'b0;
    ticks = 0;
    while (busy && ticks < 40) begin
      do_tick();
      ticks++;
    end
    check("t3_ticks_to_idle", 32'(ticks), 32'd11);
    check("t3_idle_addr", 32'(ADDR), 32'h00);
    repeat (3) do_tick();
    check("t3_held_addr", 32'(ADDR), 32'h00);

    // Resume from FINISH without a phase reset.
    tone_on = 1'b1;
    @(negedge CLK);
    repeat (12) do_tick();
    check("t4_addrC0", 32'(ADDR), 32'hC0);
    tone_on = 1'b0;
    repeat (2) @(negedge CLK);
    check("t4_finish_busy", 32'(busy), 32'd1);
    tone_on = 1'b1;
    do_tick();
    check("t4_addrD0", 32'(ADDR), 32'hD0);
    check("t4_busy", 32'(busy), 32'd1);
    stop_tone();

    // Retune coincident with a tick.
    load_word(24'h010000);
    do_tick();
    tone_on = 1'b1;
    @(negedge CLK);
    repeat (3) do_tick();
    check("t5_addr3", 32'(ADDR), 32'h03);
    sample_tick = 1'b1;
    tune_load = 1'b1;
    tune_word = 24'h020000;
    @(negedge CLK);
    sample_tick = 1'b0;
    tune_load = 1'b0;
    check("t5_old_step", 32'(ADDR), 32'h04);
    repeat (3) @(negedge CLK);
    do_tick();
    check("t5_new_step", 32'(ADDR), 32'h06);
    do_tick();
    check("t5_new_step2", 32'(ADDR), 32'h08);
    stop_tone();
`endif

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      sample_tick = ($urandom_range(0, 3) == 0);
      tune_load = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 4);
      rw = 24'($urandom());
      tune_word = (r == 0) ? 24'h000000 : (r == 1) ? 24'h100000 : (r == 2) ? 24'h080000 : rw;
      if ($urandom_range(0, 49) == 0) tone_on = ~tone_on;
      @(negedge CLK);
    end
    sample_tick = 1'b0; tune_load = 1'b0; tone_on = 1'b0;
    @(negedge CLK);

    // Asynchronous reset in the middle of a tone.
    load_word(24'h123456);
    do_tick();
    tone_on = 1'b1;
    @(negedge CLK);
    repeat (7) do_tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 RESETn = 1'b0;
    tone_on = 1'b0;
    #1;
    check("rst_async_addr", 32'(ADDR), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_wrap", 32'(wrap_pulse), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

`ifdef TONE_GLIDE_EN
    // Glide 0x010000 -> 0x010400 over four ticks, then reset mid-glide.
    load_word(24'h010000);
    repeat (260) do_tick();
    tone_on = 1'b1;
    load_word(24'h010400);
    repeat (20) do_tick();
    check("t6_glide_addr", 32'(ADDR), 32'h14);
    load_word(24'h000400);
    repeat (2) do_tick();
    #2 RESETn = 1'b0;
    tone_on = 1'b0;
    #1;
    check("t6_rst_addr", 32'(ADDR), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wrap", 32'(wrap_pulse), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
